// File: rtl/vend_ctrl_if.sv
// Vending controller bus: coin/cancel inputs, dispense and change handshakes,
// and the credit/sales status outputs.
interface vend_ctrl_if;
    logic [1:0] coin;
    logic       coin_valid;
    logic       cancel;
    logic       disp_ack;
    logic       chg_ack;
    logic [5:0] credit;
    logic       disp_req;
    logic       chg_req;
    logic [5:0] chg_amt;
    logic       coin_rej;
    logic       busy;
    logic [7:0] sales;

    modport master (
        output coin, coin_valid, cancel, disp_ack, chg_ack,
        input  credit, disp_req, chg_req, chg_amt, coin_rej, busy, sales
    );

    modport slave (
        input  coin, coin_valid, cancel, disp_ack, chg_ack,
        output credit, disp_req, chg_req, chg_amt, coin_rej, busy, sales
    );
endinterface

// File: rtl/vend_ctrl.sv
// Vending machine controller: accumulates coins, requests a dispense once the
// price is met, then hands any surplus or a cancelled credit to the change unit.
module vend_ctrl #(
    parameter int PRICE = 30
) (
    input  logic        clk,
    input  logic        rst,
    vend_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        DISPENSE = 3'd2,
        CHANGE   = 3'd3,
        REFUND   = 3'd4
    } state_t;

    localparam logic [5:0] PRICE_C = 6'(PRICE);

    state_t     state_q, state_d;
    logic [5:0] credit_q, credit_d;
    logic       disp_req_q, disp_req_d;
    logic       chg_req_q, chg_req_d;
    logic [5:0] chg_amt_q, chg_amt_d;
    logic       coin_rej_q, coin_rej_d;
    logic [7:0] sales_q, sales_d;

    logic       coin_hit;
    logic [5:0] coin_val;
    logic [5:0] credit_sum;

    always_comb begin
        case (bus.coin)
            2'b01:   coin_val = 6'd5;
            2'b10:   coin_val = 6'd10;
            2'b11:   coin_val = 6'd25;
            default: coin_val = 6'd0;
        endcase
    end

    // A zero coin code is treated as "no coin" even when coin_valid is high.
    assign coin_hit   = bus.coin_valid && (bus.coin != 2'b00);
    assign credit_sum = credit_q + coin_val;

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        disp_req_d = disp_req_q;
        chg_req_d  = chg_req_q;
        chg_amt_d  = chg_amt_q;
        coin_rej_d = 1'b0;
        sales_d    = sales_q;

        case (state_q)
            IDLE, COLLECT: begin
                // Cancel outranks a simultaneous coin, which is bounced.
                if (bus.cancel && coin_hit)
                    coin_rej_d = 1'b1;
                if (bus.cancel && state_q == COLLECT && credit_q != 6'd0) begin
                    state_d   = REFUND;
                    chg_req_d = 1'b1;
                    chg_amt_d = credit_q;
                    credit_d  = 6'd0;
                end else if (coin_hit && !bus.cancel) begin
                    credit_d = credit_sum;
                    if (credit_sum >= PRICE_C) begin
                        state_d    = DISPENSE;
                        disp_req_d = 1'b1;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end

            DISPENSE: begin
                coin_rej_d = coin_hit;
                if (bus.disp_ack) begin
                    disp_req_d = 1'b0;
                    sales_d    = sales_q + 8'd1;
                    credit_d   = 6'd0;
                    if (credit_q > PRICE_C) begin
                        state_d   = CHANGE;
                        chg_req_d = 1'b1;
                        chg_amt_d = credit_q - PRICE_C;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            CHANGE, REFUND: begin
                coin_rej_d = coin_hit;
                if (bus.chg_ack) begin
                    chg_req_d = 1'b0;
                    chg_amt_d = 6'd0;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d    = IDLE;
                credit_d   = 6'd0;
                disp_req_d = 1'b0;
                chg_req_d  = 1'b0;
                chg_amt_d  = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            credit_q   <= 6'd0;
            disp_req_q <= 1'b0;
            chg_req_q  <= 1'b0;
            chg_amt_q  <= 6'd0;
            coin_rej_q <= 1'b0;
            sales_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            disp_req_q <= disp_req_d;
            chg_req_q  <= chg_req_d;
            chg_amt_q  <= chg_amt_d;
            coin_rej_q <= coin_rej_d;
            sales_q    <= sales_d;
        end
    end

    assign bus.credit   = credit_q;
    assign bus.disp_req = disp_req_q;
    assign bus.chg_req  = chg_req_q;
    assign bus.chg_amt  = chg_amt_q;
    assign bus.coin_rej = coin_rej_q;
    assign bus.busy     = (state_q == DISPENSE) || (state_q == CHANGE) || (state_q == REFUND);
    assign bus.sales    = sales_q;

endmodule
